// File: rtl/divider_reconstruct_pkg.sv
// rtl/divider_reconstruct_pkg.sv - shared widths, FSM states and counter sizing for the reconstruct checker
package divider_reconstruct_pkg;

    localparam int N_W = 16;
    localparam int D_W = 8;
    localparam int Q_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Never returns less than 1 so a single-bit quotient still gets a counter.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        if (width < 1) begin
            width = 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/divider_reconstruct_seq.sv
// rtl/divider_reconstruct_seq.sv - rebuilds n_hat = q*d + r by LSB-first shift-add and reports n - n_hat
module divider_reconstruct_seq
    import divider_reconstruct_pkg::*;
#(
    parameter int N_W = divider_reconstruct_pkg::N_W,
    parameter int D_W = divider_reconstruct_pkg::D_W,
    parameter int Q_W = divider_reconstruct_pkg::Q_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N_W-1:0] n,
    input  logic [D_W-1:0] d,
    input  logic [Q_W-1:0] q,
    input  logic [Q_W-1:0] r,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N_W-1:0] n_hat,
    output logic [N_W:0]   err,
    output logic           exact,
    output logic           dz
);

    localparam int A_W   = N_W + 1;
    localparam int CNT_W = clog2(Q_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Q_W - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [N_W-1:0]    r_n;
    logic [D_W-1:0]    r_d;
    logic [Q_W-1:0]    r_q;
    logic [A_W-1:0]    r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [N_W-1:0]    r_n_hat;
    logic [A_W-1:0]    r_err;
    logic              r_exact;
    logic              r_dz;
    logic [A_W-1:0]    w_addend;
    logic [A_W-1:0]    w_err;

    assign w_addend = A_W'(r_d) << r_cnt;
    // err keeps the full accumulator even when n_hat has to truncate it.
    assign w_err    = A_W'(r_n) - r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (in_valid) w_state_nxt = MUL;
            MUL:  if (r_cnt == CNT_LAST) w_state_nxt = FIN;
            FIN:  w_state_nxt = DONE;
            DONE: if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n     <= '0;
            r_d     <= '0;
            r_q     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_n_hat <= '0;
            r_err   <= '0;
            r_exact <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_n   <= n;
                        r_d   <= d;
                        r_q   <= q;
                        r_acc <= A_W'(r);
                        r_cnt <= '0;
                    end
                end
                MUL: begin
                    if (r_q[r_cnt]) begin
                        r_acc <= r_acc + w_addend;
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                FIN: begin
                    r_n_hat <= r_acc[N_W-1:0];
                    r_err   <= w_err;
                    r_exact <= (w_err == '0);
                    r_dz    <= (r_d == '0);
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign n_hat     = r_n_hat;
    assign err       = r_err;
    assign exact     = r_exact;
    assign dz        = r_dz;

endmodule
